// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with pending/mask/mode registers, priority vector, registered IRQ_O
// Optional macro IRQ_CTRL_SYNC_EN inserts a two-flop synchronizer on HWINT_I.
module irq_ctrl #(
  parameter int N_IRQ = 6
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             WE_I,
  input  logic [1:0]       ADD_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  input  logic [N_IRQ-1:0] HWINT_I,
  input  logic             ACK_I,
  output logic             IRQ_O
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_VECT = 2'd3;

  logic [N_IRQ-1:0] hw;

`ifdef IRQ_CTRL_SYNC_EN
  // Edge detection stays disarmed until the synchronizer holds real samples.
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [N_IRQ-1:0] sync1, sync2;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= HWINT_I;
      sync2 <= sync1;
    end
  end

  assign hw = sync2;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign hw = HWINT_I;
`endif

  logic [N_IRQ-1:0] pend, mask_en, mode, hist;
  logic [N_IRQ-1:0] act, rise, clr, pend_nxt;
  logic             gie, irq_q, armed, vvld, wr_pend;
  logic [1:0]       arm_cnt;
  logic [2:0]       vidx;
  logic             unused_dat;

  assign unused_dat = ^DAT_I[30:N_IRQ];
  assign armed      = (arm_cnt == ARM_CYC);
  assign act        = pend & mask_en;
  assign wr_pend    = WE_I && (ADD_I == A_PEND);
  // A line held high through reset is not an edge until it falls and rises again.
  assign rise       = hw & ~hist & {N_IRQ{armed}};

  always_comb begin
    vvld = 1'b0;
    vidx = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        vvld = 1'b1;
        vidx = 3'(i);
      end
    end
  end

  always_comb begin
    clr      = '0;
    pend_nxt = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i]      = (wr_pend && DAT_I[i]) || (ACK_I && vvld && (vidx == 3'(i)));
      pend_nxt[i] = mode[i] ? (rise[i] | (pend[i] & ~clr[i])) : hw[i];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pend    <= '0;
      mask_en <= '0;
      gie     <= 1'b0;
      mode    <= '0;
      hist    <= '0;
      arm_cnt <= 2'd0;
      irq_q   <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      hist  <= hw;
      irq_q <= gie & (|act);
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      if (WE_I && (ADD_I == A_MASK)) begin
        gie     <= DAT_I[31];
        mask_en <= DAT_I[N_IRQ-1:0];
      end
      if (WE_I && (ADD_I == A_MODE)) begin
        mode <= DAT_I[N_IRQ-1:0];
      end
    end
  end

  always_comb begin
    DAT_O = 32'd0;
    case (ADD_I)
      A_PEND: DAT_O = {{(32 - N_IRQ){1'b0}}, pend};
      A_MASK: DAT_O = {gie, {(31 - N_IRQ){1'b0}}, mask_en};
      A_MODE: DAT_O = {{(32 - N_IRQ){1'b0}}, mode};
      A_VECT: DAT_O = {vvld, 28'd0, vidx};
      default: DAT_O = 32'd0;
    endcase
  end

  assign IRQ_O = irq_q;

endmodule
